// File: rtl/dht11_pkg.sv
// Shared definitions for the DHT11 frame path: frame geometry, byte slots,
// result status codes and the checker's state encoding.
package dht11_pkg;

  localparam int FRAME_W   = 40;
  localparam int NUM_BYTES = 5;

  localparam int B_HUM_INT  = 0;
  localparam int B_HUM_DEC  = 1;
  localparam int B_TEMP_INT = 2;
  localparam int B_TEMP_DEC = 3;
  localparam int B_CSUM     = 4;

  localparam logic [1:0] ST_OK   = 2'b00;
  localparam logic [1:0] ST_CSUM = 2'b01;
  localparam logic [1:0] ST_SENS = 2'b10;
  localparam logic [1:0] ST_TMO  = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_KICK,
    S_ARM,
    S_MEAS,
    S_CHECK,
    S_FAIL,
    S_GAP,
    S_OUT
  } state_e;

  typedef logic [NUM_BYTES-1:0][7:0] frame_bytes_t;

endpackage

// File: rtl/dht11_frame_decode.sv
// Restores the reader's bit-reversed byte layout and checks the 8-bit
// additive checksum. Purely combinational; also used by the display path.
module dht11_frame_decode
  import dht11_pkg::*;
(
  input  logic [FRAME_W-1:0] raw_i,
  output frame_bytes_t       bytes_o,
  output logic               csum_ok_o
);

  frame_bytes_t dec;
  logic [7:0]   sum;

  // The reader shifts MSB-first into ascending indices, so each byte is mirrored.
  always_comb begin
    dec = '0;
    for (int k = 0; k < NUM_BYTES; k++) begin
      for (int b = 0; b < 8; b++) begin
        dec[k][b] = raw_i[8*k + 7 - b];
      end
    end
    sum = dec[B_HUM_INT] + dec[B_HUM_DEC] + dec[B_TEMP_INT] + dec[B_TEMP_DEC];
  end

  assign bytes_o   = dec;
  assign csum_ok_o = (sum == dec[B_CSUM]);

endmodule

// File: rtl/dht11_frame_checker.sv
// Sequences DHT11 reads through the reader's reset, validates each frame,
// retries failures after a spacing gap and hands results out on valid/ready.
module dht11_frame_checker
  import dht11_pkg::*;
#(
  parameter int unsigned PERIOD_CYC    = 100_000_000,
  parameter int unsigned TIMEOUT_CYC   = 10_000_000,
  parameter int unsigned RETRY_GAP_CYC = 50_000_000,
  parameter int unsigned MAX_RETRY     = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               auto_en,
  output logic               sens_rst,
  input  logic               sens_wait,
  input  logic               sens_error,
  input  logic [FRAME_W-1:0] sens_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [7:0]         hum_int,
  output logic [7:0]         hum_dec,
  output logic [7:0]         temp_int,
  output logic [7:0]         temp_dec,
  output logic [1:0]         status,
  output logic               busy
);

  state_e             state_q, state_d;
  logic [31:0]        cnt_q, cnt_d;
  logic [31:0]        period_q, period_d;
  logic [31:0]        retry_q, retry_d;
  logic               pending_q, pending_d;
  logic               err_seen_q, err_seen_d;
  logic [FRAME_W-1:0] raw_q, raw_d;
  logic [1:0]         code_q, code_d;
  logic [3:0][7:0]    res_q, res_d;
  logic [1:0]         status_q, status_d;

  frame_bytes_t bytes;
  logic         csum_ok;
  logic         tick;
  logic         trigger;

  dht11_frame_decode u_decode (
    .raw_i    (raw_q),
    .bytes_o  (bytes),
    .csum_ok_o(csum_ok)
  );

  assign tick     = auto_en && (period_q == PERIOD_CYC - 1);
  assign trigger  = start || tick;
  assign period_d = (!auto_en || tick) ? '0 : period_q + 1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      period_q   <= '0;
      retry_q    <= '0;
      pending_q  <= 1'b0;
      err_seen_q <= 1'b0;
      raw_q      <= '0;
      code_q     <= ST_OK;
      res_q      <= '0;
      status_q   <= ST_OK;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      period_q   <= period_d;
      retry_q    <= retry_d;
      pending_q  <= pending_d;
      err_seen_q <= err_seen_d;
      raw_q      <= raw_d;
      code_q     <= code_d;
      res_q      <= res_d;
      status_q   <= status_d;
    end
  end

  // cnt_q times KICK, GAP and the read timeout; it is not cleared on ARM->MEAS
  // so the timeout covers the whole read from the moment the reader is released.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + 1;
    retry_d    = retry_q;
    pending_d  = pending_q || (trigger && (state_q != S_IDLE));
    err_seen_d = err_seen_q;
    raw_d      = raw_q;
    code_d     = code_q;
    res_d      = res_q;
    status_d   = status_q;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (trigger || pending_q) begin
          retry_d    = '0;
          err_seen_d = 1'b0;
          pending_d  = 1'b0;
          state_d    = S_KICK;
        end
      end
      S_KICK: begin
        if (cnt_q == 32'd1) begin
          cnt_d   = '0;
          state_d = S_ARM;
        end
      end
      S_ARM: begin
        if (sens_wait) begin
          state_d = S_MEAS;
        end else if (cnt_q == TIMEOUT_CYC - 1) begin
          code_d  = ST_TMO;
          state_d = S_FAIL;
        end
      end
      S_MEAS: begin
        if (sens_error) begin
          err_seen_d = 1'b1;
        end
        if (!sens_wait && !sens_error) begin
          raw_d   = sens_data;
          state_d = S_CHECK;
        end else if (cnt_q == TIMEOUT_CYC - 1) begin
          code_d  = ST_TMO;
          state_d = S_FAIL;
        end
      end
      S_CHECK: begin
        if (err_seen_q) begin
          code_d  = ST_SENS;
          state_d = S_FAIL;
        end else if (!csum_ok) begin
          code_d  = ST_CSUM;
          state_d = S_FAIL;
        end else begin
          res_d    = {bytes[B_HUM_INT], bytes[B_HUM_DEC], bytes[B_TEMP_INT], bytes[B_TEMP_DEC]};
          status_d = ST_OK;
          state_d  = S_OUT;
        end
      end
      S_FAIL: begin
        cnt_d = '0;
        if (retry_q < MAX_RETRY) begin
          retry_d = retry_q + 1;
          state_d = S_GAP;
        end else begin
          res_d    = '0;
          status_d = code_q;
          state_d  = S_OUT;
        end
      end
      S_GAP: begin
        if (cnt_q == RETRY_GAP_CYC - 1) begin
          cnt_d      = '0;
          err_seen_d = 1'b0;
          state_d    = S_KICK;
        end
      end
      S_OUT: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign sens_rst  = !((state_q == S_ARM) || (state_q == S_MEAS));
  assign out_valid = (state_q == S_OUT);
  assign busy      = (state_q != S_IDLE);
  assign hum_int   = res_q[3];
  assign hum_dec   = res_q[2];
  assign temp_int  = res_q[1];
  assign temp_dec  = res_q[0];
  assign status    = status_q;

endmodule

// File: tb/tb_dht11_frame_checker.sv
// Scoreboard bench: a behavioural reader answers each release of sens_rst from
// a queue of scripted attempts; a monitor compares every presented result.
module tb_dht11_frame_checker;

  localparam int P = 2000;
  localparam int T = 300;
  localparam int G = 100;
  localparam int R = 2;

  localparam int K_GOOD   = 0;
  localparam int K_ERR    = 1;
  localparam int K_NOWAIT = 2;
  localparam int K_LONG   = 3;

  // Hand-encoded frames: every byte bit-mirrored into its 8-bit slot.
  localparam logic [39:0] RAW_GOOD  = 40'h4A_C0_18_00_EC;
  localparam logic [39:0] RAW_BAD   = 40'hCA_C0_18_00_EC;
  localparam logic [39:0] RAW_CARRY = 40'hA0_C0_40_80_FF;

  typedef struct {
    int          kind;
    logic [39:0] raw;
  } att_t;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  st;
    bit          lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst, start, auto_en, out_ready;
  logic        sens_rst, sens_wait, sens_error;
  logic [39:0] sens_data;
  logic        out_valid, busy;
  logic [7:0]  hum_int, hum_dec, temp_int, temp_dec;
  logic [1:0]  status;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   start_cyc = 0;
  att_t attempts[$];
  exp_t expq[$];
  int   falls[$];
  int   drops[$];

  dht11_frame_checker #(
    .PERIOD_CYC   (P),
    .TIMEOUT_CYC  (T),
    .RETRY_GAP_CYC(G),
    .MAX_RETRY    (R)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .auto_en   (auto_en),
    .sens_rst  (sens_rst),
    .sens_wait (sens_wait),
    .sens_error(sens_error),
    .sens_data (sens_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .hum_int   (hum_int),
    .hum_dec   (hum_dec),
    .temp_int  (temp_int),
    .temp_dec  (temp_dec),
    .status    (status),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [39:0] act, input logic [39:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic flagFail(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s: got no event, expected one", name);
  endtask

  task automatic waitCycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulseStart();
    start     = 1'b1;
    start_cyc = cyc;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic applyStimulus(input exp_t e);
    expq.push_back(e);
    falls.delete();
    drops.delete();
    pulseStart();
  endtask

  task automatic waitIdle(input string name, input int budget);
    bit done = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (!busy) begin
        done = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    if (!done) flagFail(name);
  endtask

  task automatic waitValid(input string name, input int budget);
    bit done = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (out_valid) begin
        done = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    if (!done) flagFail(name);
  endtask

  // Reader model: answers each release of sens_rst with the next scripted attempt.
  initial begin : sensor_model
    att_t a;
    int   hold;
    bit   aborted;
    sens_wait  = 1'b0;
    sens_error = 1'b0;
    sens_data  = '0;
    forever begin
      @(posedge clk);
      #1;
      if (!sens_rst) begin
        falls.push_back(cyc);
        if (attempts.size() > 0) a = attempts.pop_front();
        else a = '{kind: K_NOWAIT, raw: '0};
        if (a.kind != K_NOWAIT) begin
          hold    = (a.kind == K_ERR) ? 100 : (a.kind == K_LONG) ? 500 : 40;
          aborted = 1'b0;
          for (int i = 0; i < 2 + hold && !aborted; i++) begin
            if (i == 2) begin
              sens_wait  = 1'b1;
              sens_data  = a.raw;
              sens_error = (a.kind == K_ERR);
            end
            @(posedge clk);
            #1;
            if (sens_rst) aborted = 1'b1;
          end
          sens_wait  = 1'b0;
          sens_error = 1'b0;
          if (!aborted) drops.push_back(cyc);
        end
        while (!sens_rst) begin
          @(posedge clk);
          #1;
        end
      end
    end
  end

  // Monitor: pops the scoreboard on each new result and checks the handshake.
  initial begin : monitor
    exp_t        e;
    logic [39:0] cap;
    logic [39:0] cur;
    int          rise_cyc;
    bit          prev_valid;
    bit          hs_prev;
    rise_cyc   = -1;
    prev_valid = 1'b0;
    hs_prev    = 1'b0;
    forever begin
      @(negedge clk);
      cur = {hum_int, hum_dec, temp_int, temp_dec, 6'd0, status};
      if (hs_prev) checkOutput("valid_drop", 40'(out_valid), 40'(0));
      if (out_valid && !prev_valid) begin
        cap      = cur;
        rise_cyc = cyc;
        if (expq.size() == 0) begin
          flagFail("unexpected_result");
        end else begin
          e = expq.pop_front();
          checkOutput("status", 40'(status), 40'(e.st));
          checkOutput("data", 40'({hum_int, hum_dec, temp_int, temp_dec}), 40'(e.data));
          if (e.lat && drops.size() > 0)
            checkOutput("valid_latency", 40'(cyc - drops[drops.size()-1]), 40'(2));
        end
      end
      if (out_valid && out_ready && cyc != rise_cyc) checkOutput("hold_stable", cur, cap);
      hs_prev    = out_valid && out_ready;
      prev_valid = out_valid;
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("[TB] FAIL watchdog: got no finish, expected one");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    int r;
    int found;
    rst       = 1'b1;
    start     = 1'b0;
    auto_en   = 1'b0;
    out_ready = 1'b1;
    waitCycles(3);
    rst = 1'b0;
    checkOutput("rst_sens_rst", 40'(sens_rst), 40'(1));
    checkOutput("rst_out_valid", 40'(out_valid), 40'(0));
    checkOutput("rst_busy", 40'(busy), 40'(0));
    checkOutput("rst_outputs", {hum_int, hum_dec, temp_int, temp_dec, 6'd0, status}, 40'(0));

    $display("[TB] good frame 55.0 RH / 24.3 C");
    attempts.push_back('{kind: K_GOOD, raw: RAW_GOOD});
    applyStimulus('{data: 32'h37_00_18_03, st: 2'b00, lat: 1'b1});
    waitIdle("good_idle", 2000);
    checkOutput("good_attempts", 40'(falls.size()), 40'(1));
    if (falls.size() > 0) checkOutput("kick_latency", 40'(falls[0] - start_cyc), 40'(3));

    $display("[TB] checksum carry wrap");
    attempts.push_back('{kind: K_GOOD, raw: RAW_CARRY});
    applyStimulus('{data: 32'hFF_01_02_03, st: 2'b00, lat: 1'b1});
    waitIdle("carry_idle", 2000);

    $display("[TB] bad checksum on every attempt");
    repeat (3) attempts.push_back('{kind: K_GOOD, raw: RAW_BAD});
    applyStimulus('{data: 32'h0, st: 2'b01, lat: 1'b0});
    waitIdle("csum_idle", 5000);
    checkOutput("csum_attempts", 40'(falls.size()), 40'(3));
    if (falls.size() >= 3 && drops.size() >= 2) begin
      checkOutput("csum_gap1", 40'(falls[1] - drops[0]), 40'(G + 5));
      checkOutput("csum_gap2", 40'(falls[2] - drops[1]), 40'(G + 5));
    end

    $display("[TB] sensor error then good retry");
    attempts.push_back('{kind: K_ERR, raw: RAW_GOOD});
    attempts.push_back('{kind: K_GOOD, raw: RAW_GOOD});
    applyStimulus('{data: 32'h37_00_18_03, st: 2'b00, lat: 1'b1});
    waitIdle("serr_idle", 5000);
    checkOutput("serr_attempts", 40'(falls.size()), 40'(2));

    $display("[TB] timeout on every attempt");
    repeat (3) attempts.push_back('{kind: K_NOWAIT, raw: '0});
    applyStimulus('{data: 32'h0, st: 2'b11, lat: 1'b0});
    waitIdle("tmo_idle", 5000);
    checkOutput("tmo_attempts", 40'(falls.size()), 40'(3));
    if (falls.size() >= 2) checkOutput("tmo_spacing", 40'(falls[1] - falls[0]), 40'(T + G + 3));

    $display("[TB] held result with pending start");
    out_ready = 1'b0;
    attempts.push_back('{kind: K_GOOD, raw: RAW_GOOD});
    attempts.push_back('{kind: K_GOOD, raw: RAW_CARRY});
    applyStimulus('{data: 32'h37_00_18_03, st: 2'b00, lat: 1'b1});
    waitValid("hs_valid", 2000);
    waitCycles(500);
    applyStimulus('{data: 32'hFF_01_02_03, st: 2'b00, lat: 1'b1});
    waitCycles(500);
    out_ready = 1'b1;
    waitCycles(1);
    checkOutput("hs_valid_low", 40'(out_valid), 40'(0));
    checkOutput("hs_idle", 40'(busy), 40'(0));
    waitCycles(1);
    checkOutput("pending_kick", 40'(busy), 40'(1));
    waitIdle("pending_idle", 2000);

    $display("[TB] reset during measurement");
    attempts.push_back('{kind: K_LONG, raw: RAW_GOOD});
    falls.delete();
    pulseStart();
    for (int i = 0; i < 200 && !sens_wait; i++) waitCycles(1);
    checkOutput("long_meas", 40'(sens_wait), 40'(1));
    waitCycles(5);
    attempts.push_back('{kind: K_GOOD, raw: RAW_CARRY});
    expq.push_back('{data: 32'hFF_01_02_03, st: 2'b00, lat: 1'b1});
    drops.delete();
    rst     = 1'b1;
    auto_en = 1'b1;
    r       = cyc;
    waitCycles(1);
    rst = 1'b0;
    checkOutput("mid_rst_sens_rst", 40'(sens_rst), 40'(1));
    checkOutput("mid_rst_out_valid", 40'(out_valid), 40'(0));
    checkOutput("mid_rst_busy", 40'(busy), 40'(0));
    found = -1;
    for (int i = 0; i < P + 50; i++) begin
      if (busy) begin
        found = cyc;
        break;
      end
      waitCycles(1);
    end
    auto_en = 1'b0;
    checkOutput("auto_first_start", 40'(found - r), 40'(P + 1));
    waitIdle("auto_idle", 2000);

    waitCycles(5);
    checkOutput("scoreboard_drained", 40'(expq.size()), 40'(0));
    checkOutput("attempts_used", 40'(attempts.size()), 40'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
